// File: rtl/prbs7_ber_ctrl.sv
// Bit-slip alignment, lock qualification and error-window accumulation for the 64-bit PRBS7 checker.
// Define PRBS_RELOCK_EN to re-enter alignment when a measured word carries RELOCK_THRESH or more errors.
module prbs7_ber_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_WORDS    = 32,
  parameter int unsigned MAX_SLIPS     = 64,
  parameter int unsigned RELOCK_THRESH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] windowLen,
  input  logic [6:0]  errorCounter,
  output logic        bitslip,
  output logic        busy,
  output logic        locked,
  output logic        done,
  output logic        alignFail,
  output logic [6:0]  slipCount,
  output logic [31:0] wordCount,
  output logic [39:0] errorTotal,
  output logic [3:0]  relockCount
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RUN_W = (LOCK_WORDS > 1) ? $clog2(LOCK_WORDS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_LOCK,
    ST_MEASURE,
    ST_DONE
  } state_t;

  state_t             state_q;
  logic [SET_W-1:0]   settle_q;
  logic [RUN_W-1:0]   run_q;
  logic [31:0]        window_q;
  logic               bitslip_q;
  logic               busy_q;
  logic               locked_q;
  logic               done_q;
  logic               align_fail_q;
  logic [6:0]         slip_cnt_q;
  logic [31:0]        word_cnt_q;
  logic [39:0]        err_total_q;

  logic [31:0]        word_cnt_d;
  logic [39:0]        err_total_d;
  logic               settle_end;
  logic               run_end;
  logic               slips_spent;
  logic               err_zero;

  assign word_cnt_d  = word_cnt_q + 32'd1;
  assign err_total_d = err_total_q + {33'd0, errorCounter};
  assign settle_end  = (settle_q == SET_W'(SETTLE_CYCLES - 1));
  assign run_end     = (run_q == RUN_W'(LOCK_WORDS - 1));
  assign slips_spent = (slip_cnt_q == 7'(MAX_SLIPS));
  assign err_zero    = (errorCounter == 7'd0);

`ifdef PRBS_RELOCK_EN
  logic [3:0] relock_q;
  logic       relock_hit;
  assign relock_hit = ({25'd0, errorCounter} >= 32'(RELOCK_THRESH));
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      settle_q     <= '0;
      run_q        <= '0;
      window_q     <= '0;
      bitslip_q    <= 1'b0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
      done_q       <= 1'b0;
      align_fail_q <= 1'b0;
      slip_cnt_q   <= '0;
      word_cnt_q   <= '0;
      err_total_q  <= '0;
`ifdef PRBS_RELOCK_EN
      relock_q     <= '0;
`endif
    end else if (abort) begin
      // Results and alignFail stay visible after an abort.
      state_q   <= ST_IDLE;
      bitslip_q <= 1'b0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      bitslip_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_ALIGN;
            settle_q     <= '0;
            window_q     <= windowLen;
            busy_q       <= 1'b1;
            locked_q     <= 1'b0;
            align_fail_q <= 1'b0;
            slip_cnt_q   <= '0;
            word_cnt_q   <= '0;
            err_total_q  <= '0;
`ifdef PRBS_RELOCK_EN
            relock_q     <= '0;
`endif
          end
        end

        ST_ALIGN: begin
          if (settle_end) begin
            state_q <= ST_LOCK;
            run_q   <= '0;
          end else begin
            settle_q <= settle_q + SET_W'(1);
          end
        end

        ST_LOCK: begin
          if (err_zero) begin
            if (run_end) begin
              state_q  <= ST_MEASURE;
              locked_q <= 1'b1;
            end else begin
              run_q <= run_q + RUN_W'(1);
            end
          end else if (slips_spent) begin
            state_q      <= ST_DONE;
            align_fail_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end else begin
            state_q    <= ST_ALIGN;
            settle_q   <= '0;
            bitslip_q  <= 1'b1;
            slip_cnt_q <= slip_cnt_q + 7'd1;
          end
        end

        ST_MEASURE: begin
          if (window_q == 32'd0) begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            done_q   <= 1'b1;
          end
`ifdef PRBS_RELOCK_EN
          else if (relock_hit) begin
            // The offending word is dropped and the window restarts from scratch.
            state_q     <= ST_ALIGN;
            settle_q    <= '0;
            locked_q    <= 1'b0;
            slip_cnt_q  <= '0;
            word_cnt_q  <= '0;
            err_total_q <= '0;
            if (relock_q != 4'hF) begin
              relock_q <= relock_q + 4'd1;
            end
          end
`endif
          else begin
            word_cnt_q  <= word_cnt_d;
            err_total_q <= err_total_d;
            if (word_cnt_d == window_q) begin
              state_q  <= ST_DONE;
              busy_q   <= 1'b0;
              locked_q <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign bitslip    = bitslip_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign done       = done_q;
  assign alignFail  = align_fail_q;
  assign slipCount  = slip_cnt_q;
  assign wordCount  = word_cnt_q;
  assign errorTotal = err_total_q;

`ifdef PRBS_RELOCK_EN
  assign relockCount = relock_q;
`else
  // Relock is compiled out; the threshold has no effect and the count reads zero.
  assign relockCount = 4'(RELOCK_THRESH) & 4'd0;
`endif

endmodule

// File: tb/tb_prbs7_ber_ctrl.sv
// Directed and randomized bench for prbs7_ber_ctrl; expectations come from the timing and summing rules.
module tb_prbs7_ber_ctrl;
  localparam int S  = 16;
  localparam int L  = 32;
  localparam int MS = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] windowLen;
  logic [6:0]  errorCounter;
  logic        bitslip;
  logic        busy;
  logic        locked;
  logic        done;
  logic        alignFail;
  logic [6:0]  slipCount;
  logic [31:0] wordCount;
  logic [39:0] errorTotal;
  logic [3:0]  relockCount;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc = 0;
  int nslip, first_slip, last_slip, min_gap, ndone;
  int pat [0:255];

  prbs7_ber_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .windowLen(windowLen), .errorCounter(errorCounter),
    .bitslip(bitslip), .busy(busy), .locked(locked), .done(done),
    .alignFail(alignFail), .slipCount(slipCount), .wordCount(wordCount),
    .errorTotal(errorTotal), .relockCount(relockCount)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bitslip) begin
      if (nslip == 0) first_slip = cyc;
      else if (cyc - last_slip < min_gap) min_gap = cyc - last_slip;
      last_slip = cyc;
      nslip++;
    end
    if (done) ndone++;
  endtask

  task automatic clear_stats();
    nslip = 0; first_slip = -1; last_slip = -1; min_gap = 1 << 30; ndone = 0;
  endtask

  task automatic wait_locked(input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound && at < 0; k++) begin
      step();
      if (locked) at = cyc;
    end
  endtask

  task automatic wait_done(input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound && at < 0; k++) begin
      step();
      if (done) at = cyc;
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_flags"}, {59'd0, bitslip, busy, locked, done, alignFail}, 64'd0);
    check({pfx, "_slipCount"}, slipCount, 0);
    check({pfx, "_wordCount"}, wordCount, 0);
    check({pfx, "_errorTotal"}, errorTotal, 0);
    check({pfx, "_relockCount"}, relockCount, 0);
  endtask

  task automatic start_test(input logic [31:0] w, output int n0);
    windowLen = w;
    start = 1'b1;
    step();
    n0 = cyc;
    start = 1'b0;
  endtask

  // After start, S settle cycles and L clean words lead to lock; then pat[0..w-1] is the window.
  task automatic run_window(input int w, input string tag, input longint exp_total);
    int n0;
    clear_stats();
    errorCounter = 7'd0;
    start_test(w, n0);
    repeat (S + L) step();
    check({tag, "_locked"}, locked, 1);
    for (int i = 0; i < w; i++) begin
      errorCounter = 7'(pat[i]);
      step();
    end
    errorCounter = 7'd0;
    check({tag, "_done_edge"}, done, 1);
    check({tag, "_errorTotal"}, errorTotal, exp_total);
    check({tag, "_wordCount"}, wordCount, w);
    check({tag, "_n_slips"}, nslip, 0);
  endtask

  initial begin
    int n0, t, t2, j, tmp;
    longint sum;
    reset = 1'b0; start = 1'b0; abort = 1'b0; windowLen = '0; errorCounter = '0;
    clear_stats();
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b1;
    step();

    // Clean run; a start during LOCK with another windowLen must be ignored.
    clear_stats();
    start_test(32'd1000, n0);
    windowLen = 32'd5;
    check("clean_busy_after_start", busy, 1);
    repeat (S + 10) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_locked(200, t);
    check("clean_lock_latency", t - n0 + 1, 1 + S + L);
    wait_done(1100, t2);
    check("clean_measure_len", t2 - t, 1000);
    check("clean_wordCount", wordCount, 1000);
    check("clean_errorTotal", errorTotal, 0);
    check("clean_no_bitslip", nslip, 0);
    step();
    check("clean_done_one_cycle", {done, busy}, 2'b00);
    check("clean_wordCount_held", wordCount, 1000);

`ifdef PRBS_RELOCK_EN
    clear_stats();
    errorCounter = 7'd0;
    start_test(32'd100, n0);
    repeat (S + L) step();
    check("relock_first_lock", locked, 1);
    repeat (30) step();
    errorCounter = 7'd20;
    step();
    errorCounter = 7'd0;
    check("relock_count", relockCount, 1);
    check("relock_totals_cleared", {wordCount, errorTotal}, 0);
    check("relock_state", {busy, locked}, 2'b10);
    repeat (S + L) step();
    check("relock_relocked", locked, 1);
    check("relock_no_slip", nslip, 0);
    repeat (100) step();
    check("relock_done", done, 1);
    check("relock_wordCount", wordCount, 100);
`else
    // Ten words of 64 and five of 1 at random positions inside a 100-word window.
    for (int i = 0; i < 100; i++) pat[i] = (i < 10) ? 64 : ((i < 15) ? 1 : 0);
    for (int i = 99; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = pat[i]; pat[i] = pat[j]; pat[j] = tmp;
    end
    run_window(100, "accum", 10 * 64 + 5 * 1);

    // Random window length and random per-word counts.
    t = int'($urandom_range(120, 40));
    sum = 0;
    for (int i = 0; i < t; i++) begin
      pat[i] = int'($urandom_range(64, 0));
      sum += pat[i];
    end
    run_window(t, "rand", sum);
`endif

    // Misalignment: errors until three slips, then clean data.
    clear_stats();
    errorCounter = 7'd5;
    start_test(32'd1000, n0);
    for (int k = 0; k < 600 && nslip < 3; k++) step();
    errorCounter = 7'd0;
    check("misalign_first_slip", first_slip - n0, S + 1);
    check("misalign_gap_ok", (min_gap >= S + 1), 1);
    check("misalign_slipCount", slipCount, 3);
    wait_locked(200, t);
    check("misalign_lock_after_slip", t - last_slip, S + L);
    check("misalign_alignFail", alignFail, 0);

    // Abort during MEASURE keeps the partial count and never produces done.
    repeat (7) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", {busy, locked, bitslip}, 3'b000);
    check("abort_wordCount_kept", wordCount, 7);
    repeat (1000) step();
    check("abort_no_done", ndone, 0);

    // Abort wins over a simultaneous start.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start", busy, 0);

    // Alignment failure with errors on every word.
    clear_stats();
    errorCounter = 7'd1;
    start_test(32'd50, n0);
    wait_done(2000, t);
    check("fail_slip_pulses", nslip, MS);
    check("fail_done_edge", t - n0, (MS + 1) * (S + 1));
    check("fail_alignFail", alignFail, 1);
    check("fail_slipCount", slipCount, MS);
    check("fail_wordCount", wordCount, 0);

    // Restart clears alignFail; reset mid-LOCK abandons the test.
    clear_stats();
    errorCounter = 7'd0;
    start_test(32'd50, n0);
    check("restart_alignFail_cleared", {alignFail, busy}, 2'b01);
    repeat (S + 5) step();
    reset = 1'b0;
    step();
    check_all_zero("midreset");
    reset = 1'b1;
    repeat (S + L + 60) step();
    check("midreset_stays_idle", {busy, locked}, 2'b00);
    check("midreset_no_done", ndone, 0);

    // Zero-length window finishes right after lock.
    clear_stats();
    start_test(32'd0, n0);
    repeat (S + L) step();
    check("zero_win_locked", locked, 1);
    step();
    check("zero_win_done", done, 1);
    check("zero_win_totals", {wordCount, errorTotal}, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/prbs7_ber_ctrl.md
# prbs7_ber_ctrl

Sequencer for the 64-bit PRBS7 checker: aligns the deserialized word to the checker with bit-slip pulses, qualifies lock, then accumulates the checker's per-word error count over a programmable window and reports a bit-error total. Sits between the SERDES deserializer (bitslip control) and the PRBS7 checker (errorCounter output), and is driven by the slow-control register block.

## Interface
Parameters:
- SETTLE_CYCLES, 16: wait after any slip or state entry before sampling errorCounter; must be at least the checker pipeline latency of 8 cycles.
- LOCK_WORDS, 32: consecutive zero-error words required for lock.
- MAX_SLIPS, 64: slip attempts before alignment is declared failed.
- RELOCK_THRESH, 16: per-word error count that forces relock (PRBS_RELOCK_EN only).

Ports:
- clk  input  1  word clock, shared with the checker.
- reset  input  1  synchronous, active-low.
- start  input  1  single-cycle request to begin a test.
- abort  input  1  returns to IDLE.
- windowLen  input  32  measurement length in words; sampled on start.
- errorCounter  input  7  checker per-word error count, 0..64.
- bitslip  output  1  one-cycle slip pulse to the deserializer.
- busy  output  1  high in ALIGN, LOCK and MEASURE.
- locked  output  1  high in MEASURE.
- done  output  1  one-cycle pulse on entry to DONE.
- alignFail  output  1  set when slips are exhausted; cleared on start.
- slipCount  output  7  slips issued in the current test.
- wordCount  output  32  words accumulated.
- errorTotal  output  40  sum of errorCounter over the window.
- relockCount  output  4  saturating relock count.

## Operation
- States: IDLE, ALIGN, LOCK, MEASURE, DONE.
- IDLE/DONE + start:
  - go to ALIGN.
  - latch windowLen.
  - clear slipCount, wordCount, errorTotal, relockCount and alignFail.
  - No slip is issued on entry.
- start is ignored in ALIGN, LOCK and MEASURE.
- ALIGN: count SETTLE_CYCLES, then go to LOCK with the zero-run counter cleared.
- LOCK:
  - errorCounter==0 increments the run counter.
  - When the run reaches LOCK_WORDS, go to MEASURE.
  - Any non-zero word:
    - if slipCount==MAX_SLIPS, set alignFail and go to DONE;
    - otherwise pulse bitslip, increment slipCount and return to ALIGN.
- MEASURE:
  - Each cycle adds zero-extended errorCounter to errorTotal and increments wordCount.
  - When wordCount reaches the latched windowLen, go to DONE.
  - windowLen==0 goes to DONE on the first MEASURE cycle with zero totals.
- Width: errorTotal is 40 bits and cannot overflow, since 2^32 words × 64 < 2^40.
- DONE: results are held until the next start.
- abort:
  - From any state, go to IDLE on the next edge with bitslip low.
  - Counters keep their values; alignFail is unchanged.
- abort and start in the same cycle: abort wins.

## Timing
- Reset (reset==0 at an edge):
  - state IDLE;
  - all outputs 0, including bitslip, busy, locked, done, alignFail and all counters.
- Reset mid-test: the test is abandoned with no done pulse.
- start at edge N: busy=1 from N+1.
- First LOCK sample at N+1+SETTLE_CYCLES.
- bitslip is registered: high for exactly the one cycle following the failing LOCK sample.
- Slip spacing: at least SETTLE_CYCLES+1 cycles between bitslip pulses.
- Minimum clean run: start to locked takes 1+SETTLE_CYCLES+LOCK_WORDS cycles.
- MEASURE lasts windowLen cycles; done pulses the cycle after the last accumulation.
- errorTotal and wordCount are stable when done is high.

## Configuration
- PRBS_RELOCK_EN defined:
  - In MEASURE, errorCounter ≥ RELOCK_THRESH increments relockCount (saturates at 15).
  - It also clears wordCount and errorTotal and goes to ALIGN without a slip.
  - slipCount is reset to 0.
  - The offending word is not accumulated.
- PRBS_RELOCK_EN undefined:
  - Every MEASURE word is accumulated regardless of size.
  - relockCount is tied to 0.
  - The RELOCK_THRESH parameter is unused.

## Test plan
- Clean run: errorCounter=0 always, windowLen=1000, defaults → no bitslip; locked after 1+16+32 cycles; done with errorTotal=0, wordCount=1000.
- Misalignment: errorCounter=5 until 3 bitslip pulses have been seen, then 0 → slipCount=3, pulses spaced ≥17 cycles, lock achieved, alignFail=0.
- Alignment failure: errorCounter=1 constantly → exactly 64 bitslip pulses, then done with alignFail=1, slipCount=64, wordCount=0.
- Accumulation: after lock, inject errorCounter=64 on 10 words and 1 on 5 words within windowLen=100 (without PRBS_RELOCK_EN) → errorTotal=645, wordCount=100.
- Relock (PRBS_RELOCK_EN): errorCounter=20 for one word mid-MEASURE → relockCount=1, totals cleared, re-entry to ALIGN, later lock with no slip.
- Control corners:
  - abort during MEASURE → IDLE next cycle, no done;
  - start while busy → ignored;
  - reset=0 mid-LOCK → all outputs 0 next cycle;
  - windowLen=0 → done immediately after lock, errorTotal=0.
